// File: rtl/serial_comparator_pkg.sv
// rtl/serial_comparator_pkg.sv - shared FSM states and result flag encodings for serial_comparator
package serial_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result flags packed as {equal, greater, less}; one-hot or all clear.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/serial_comparator_digit_compare.sv
// rtl/serial_comparator_digit_compare.sv - combinational unsigned compare of one DIGIT-bit slice
module digit_compare #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             eq,
    output logic             gt
);

    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/serial_comparator.sv
// rtl/serial_comparator.sv - MSB-first digit-serial magnitude comparator with early termination
module serial_comparator
    import serial_comparator_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIGIT     = 2,
    parameter int SIGNED_EN = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 is_signed,
    input  logic [WIDTH-1:0]                     A,
    input  logic [WIDTH-1:0]                     B,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 A_equal_B,
    output logic                                 A_greater_B,
    output logic                                 A_less_B,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]     cycles
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    idx;
    logic [2:0]       flags;
    logic             dig_eq;
    logic             dig_gt;
    logic             idx_last;
    logic             accept;
    logic             sign_flip;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign sign_flip = is_signed & (SIGNED_EN != 0);
    assign accept    = start & ((state == IDLE) | (state == DONE));
    assign idx_last  = (idx == CW'(N - 1));

    digit_compare #(
        .DIGIT (DIGIT)
    ) u_digit_compare (
        .a  (a_sh[WIDTH-1 -: DIGIT]),
        .b  (b_sh[WIDTH-1 -: DIGIT]),
        .eq (dig_eq),
        .gt (dig_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CMP;
            CMP:     if (!dig_eq || idx_last) state_next = DONE;
            DONE:    state_next = start ? CMP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            CMP:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operands shift left so the slice under test is always at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            idx    <= '0;
            flags  <= RES_NONE;
            cycles <= '0;
        end else if (accept) begin
            a_sh   <= {A[WIDTH-1] ^ sign_flip, A[WIDTH-2:0]};
            b_sh   <= {B[WIDTH-1] ^ sign_flip, B[WIDTH-2:0]};
            idx    <= '0;
            flags  <= RES_NONE;
            cycles <= '0;
        end else if (state == CMP) begin
            if (!dig_eq) begin
                flags  <= dig_gt ? RES_GT : RES_LT;
                cycles <= idx + CW'(1);
            end else if (idx_last) begin
                flags  <= RES_EQ;
                cycles <= CW'(N);
            end else begin
                idx  <= idx + CW'(1);
                a_sh <= a_sh << DIGIT;
                b_sh <= b_sh << DIGIT;
            end
        end
    end

    assign A_equal_B   = flags[2];
    assign A_greater_B = flags[1];
    assign A_less_B    = flags[0];

endmodule

// File: tb/tb_serial_comparator.sv
// tb/tb_serial_comparator.sv - directed self-checking bench for serial_comparator
module tb_serial_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       is_signed;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic       A_equal_B;
    logic       A_greater_B;
    logic       A_less_B;
    logic [2:0] cycles;

    int errors = 0;
    int checks = 0;

    serial_comparator #(
        .WIDTH     (8),
        .DIGIT     (2),
        .SIGNED_EN (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .A           (op_a),
        .B           (op_b),
        .busy        (busy),
        .done        (done),
        .A_equal_B   (A_equal_B),
        .A_greater_B (A_greater_B),
        .A_less_B    (A_less_B),
        .cycles      (cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp_flags, input int exp_cyc);
        check({tag, ".flags"}, {29'd0, A_equal_B, A_greater_B, A_less_B}, {29'd0, exp_flags});
        check({tag, ".cycles"}, {29'd0, cycles}, exp_cyc);
    endtask

    // Waits for done (bounded); reports edges from acceptance to done and busy cycles seen.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (done) break;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic sgn, input logic [2:0] exp_flags, input int exp_cyc);
        int lat;
        int bc;
        op_a = a;
        op_b = b;
        is_signed = sgn;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, bc);
        check({tag, ".latency"}, lat, exp_cyc);
        check({tag, ".busy_cycles"}, bc, exp_cyc);
        check_flags(tag, exp_flags, exp_cyc);
        tick();
        check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int done_seen;
        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        op_a = 8'h00;
        op_b = 8'h00;
        tick();
        tick();
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check_flags("reset", 3'b000, 0);
        rst = 1'b0;
        tick();

        run_cmp("eq_b7",      8'hB7, 8'hB7, 1'b0, 3'b100, 4);
        run_cmp("gt_f0_20",   8'hF0, 8'h20, 1'b0, 3'b010, 1);
        run_cmp("s_lt_80_7f", 8'h80, 8'h7F, 1'b1, 3'b001, 1);
        run_cmp("u_gt_80_7f", 8'h80, 8'h7F, 1'b0, 3'b010, 1);
        run_cmp("s_gt_05_fb", 8'h05, 8'hFB, 1'b1, 3'b010, 1);
        run_cmp("gt_3c_38",   8'h3C, 8'h38, 1'b0, 3'b010, 3);
        run_cmp("lt_34_37",   8'h34, 8'h37, 1'b0, 3'b001, 4);

        // Start pulsed mid-busy with new operands must be ignored.
        op_a = 8'h12;
        op_b = 8'h13;
        is_signed = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op_a = 8'h00;
        op_b = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ignore.done", {31'd0, done}, 32'd1);
        check_flags("ignore", 3'b001, 4);
        tick();
        check("ignore.idle_busy", {31'd0, busy}, 32'd0);
        check("ignore.done_low", {31'd0, done}, 32'd0);
        check_flags("ignore.hold", 3'b001, 4);

        // Start held through DONE: back-to-back acceptance; operand change mid-compare ignored.
        op_a = 8'hF0;
        op_b = 8'h20;
        start = 1'b1;
        tick();
        op_a = 8'h11;
        op_b = 8'h11;
        tick();
        check("b2b.done", {31'd0, done}, 32'd1);
        check_flags("b2b.first", 3'b010, 1);
        tick();
        start = 1'b0;
        check("b2b.busy", {31'd0, busy}, 32'd1);
        check("b2b.done_low", {31'd0, done}, 32'd0);
        check("b2b.cleared", {29'd0, A_equal_B, A_greater_B, A_less_B}, 32'd0);
        wait_done(lat, bc);
        check("b2b.second_latency", lat, 4);
        check_flags("b2b.second", 3'b100, 4);
        tick();

        // Reset during the second CMP cycle aborts with no done pulse; rst beats start.
        op_a = 8'h12;
        op_b = 8'h13;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.done", {31'd0, done}, 32'd0);
        check_flags("abort", 3'b000, 0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("abort.no_done", done_seen, 0);

        run_cmp("post_abort", 8'h12, 8'h13, 1'b0, 3'b001, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
